// File: rtl/rx_parser_if.sv
// Byte stream from the UART receiver into the line parser, and the parsed results back out.
// master = byte/ack source side, slave = parser side.
interface rx_parser_if #(
   parameter int DBIT = 8
);
   logic            rx_done_tick;
   logic [DBIT-1:0] rx_dout;
   logic            dump_ack;
   logic [DBIT-1:0] value;
   logic            value_valid;
   logic            parse_err;
   logic            dump_req;

   modport master (
      output rx_done_tick, rx_dout, dump_ack,
      input  value, value_valid, parse_err, dump_req
   );

   modport slave (
      input  rx_done_tick, rx_dout, dump_ack,
      output value, value_valid, parse_err, dump_req
   );
endinterface

// File: rtl/rx_parser.sv
// ASCII line parser: signed decimal numbers or a 'd' dump command, one byte per rx_done_tick.
// Latency 1 cycle from accepted byte to registered outputs; no backpressure, a byte is consumed on every tick.
module rx_parser #(
   parameter int DBIT       = 8,
   parameter int MAX_DIGITS = 3,
   parameter int ACC_W      = 10
) (
   input logic         clk,
   input logic         reset,
   rx_parser_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [ACC_W:0] POS_MAX = (ACC_W+1)'((1 << (DBIT - 1)) - 1);
   localparam logic [ACC_W:0] NEG_MAX = POS_MAX + (ACC_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIGITS  = 2'd1,
      DISCARD = 2'd2,
      UNUSED  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [DBIT-1:0]  value_q, value_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             dump_q, dump_d;

   logic             tick;
   logic             is_digit, is_term, is_minus, is_dump;
   logic             cnt_full, in_range;
   logic [3:0]       digit;

   assign tick     = bus.rx_done_tick;
   assign is_digit = (bus.rx_dout >= DBIT'(8'h30)) && (bus.rx_dout <= DBIT'(8'h39));
   assign is_term  = (bus.rx_dout == DBIT'(8'd13)) || (bus.rx_dout == DBIT'(8'd10));
   assign is_minus = (bus.rx_dout == DBIT'(8'h2D));
   assign is_dump  = (bus.rx_dout == DBIT'(8'h64));
   assign digit    = bus.rx_dout[3:0];
   assign cnt_full = (cnt_q == CNT_W'(MAX_DIGITS));
   // Negative side of the range is one larger in magnitude (two's complement).
   assign in_range = neg_q ? ({1'b0, acc_q} <= NEG_MAX) : ({1'b0, acc_q} <= POS_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         value_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         dump_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         value_q <= value_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         dump_q  <= dump_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (tick) begin
               if (is_minus || is_digit)     state_d = DIGITS;
               else if (!is_dump && !is_term) state_d = DISCARD;
            end
         end
         DIGITS: begin
            if (tick) begin
               if (is_digit) begin
                  if (cnt_full) state_d = DISCARD;
               end else if (is_term) begin
                  state_d = IDLE;
               end else begin
                  state_d = DISCARD;
               end
            end
         end
         DISCARD: begin
            if (tick && is_term) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      value_d = value_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      dump_d  = dump_q && !bus.dump_ack;
      case (state_q)
         IDLE: begin
            if (tick) begin
               if (is_minus) begin
                  neg_d = 1'b1;
                  acc_d = '0;
                  cnt_d = '0;
               end else if (is_digit) begin
                  neg_d = 1'b0;
                  acc_d = {{(ACC_W-4){1'b0}}, digit};
                  cnt_d = CNT_W'(1);
               end else if (is_dump) begin
                  dump_d = 1'b1;
               end
            end
         end
         DIGITS: begin
            if (tick) begin
               if (is_digit && !cnt_full) begin
                  acc_d = acc_q * ACC_W'(10) + {{(ACC_W-4){1'b0}}, digit};
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (is_term) begin
                  if (cnt_q == '0) begin
                     err_d = 1'b1;
                  end else if (in_range) begin
                     value_d = neg_q ? (~acc_q[DBIT-1:0] + DBIT'(1)) : acc_q[DBIT-1:0];
                     valid_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         DISCARD: begin
            if (tick && is_term) err_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.value       = value_q;
   assign bus.value_valid = valid_q;
   assign bus.parse_err   = err_q;
   assign bus.dump_req    = dump_q;

endmodule

// File: tb/tb_rx_parser.sv
// Directed bench for rx_parser: byte lines in, registered value/pulse/dump outputs checked against hand-computed values.
module tb_rx_parser;
   localparam int DBIT = 8;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   nv, ne;

   rx_parser_if #(.DBIT(DBIT)) bus ();

   rx_parser #(.DBIT(DBIT), .MAX_DIGITS(3), .ACC_W(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge with the byte's effect visible.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_dout      = b;
      bus.rx_done_tick = 1'b1;
      @(negedge clk);
      bus.rx_done_tick = 1'b0;
      nv += int'(bus.value_valid);
      ne += int'(bus.parse_err);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         nv += int'(bus.value_valid);
         ne += int'(bus.parse_err);
      end
   endtask

   task automatic check_line(input string tag, input string body, input logic [7:0] term,
                             input logic vld, input logic err, input logic [7:0] val);
      nv = 0;
      ne = 0;
      send_str(body);
      send_byte(term);
      check({tag, "_valid"}, 32'(bus.value_valid), 32'(vld));
      check({tag, "_err"},   32'(bus.parse_err),   32'(err));
      check({tag, "_value"}, 32'(bus.value),       32'(val));
      idle(1);
      check({tag, "_pulses"}, 32'(nv + ne), 32'(1));
   endtask

   initial begin
      reset            = 1'b0;
      bus.rx_done_tick = 1'b0;
      bus.rx_dout      = '0;
      bus.dump_ack     = 1'b0;
      nv = 0;
      ne = 0;
      repeat (2) @(negedge clk);
      check("rst_value", 32'(bus.value),       32'h0);
      check("rst_valid", 32'(bus.value_valid), 32'h0);
      check("rst_err",   32'(bus.parse_err),   32'h0);
      check("rst_dump",  32'(bus.dump_req),    32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Max positive, min negative, overflow keeps old value
      check_line("p127",  "127",  8'd13, 1'b1, 1'b0, 8'h7F);
      check_line("m128",  "-128", 8'd10, 1'b1, 1'b0, 8'h80);
      check_line("p128",  "128",  8'd13, 1'b0, 1'b1, 8'h80);
      check_line("m5",    "-5",   8'd13, 1'b1, 1'b0, 8'hFB);
      check_line("m129",  "-129", 8'd13, 1'b0, 1'b1, 8'hFB);

      // CRLF pair: the LF is an empty line and yields nothing
      check_line("p42", "42", 8'd13, 1'b1, 1'b0, 8'h2A);
      nv = 0;
      ne = 0;
      send_byte(8'd10);
      idle(1);
      check("lf_pulses", 32'(nv + ne), 32'h0);

      check_line("lone_minus", "-",    8'd13, 1'b0, 1'b1, 8'h2A);
      check_line("four_dig",   "1234", 8'd13, 1'b0, 1'b1, 8'h2A);
      check_line("bad_char",   "1x5",  8'd13, 1'b0, 1'b1, 8'h2A);
      check_line("lead_zero",  "0042", 8'd13, 1'b0, 1'b1, 8'h2A);
      check_line("neg_zero",   "-0",   8'd13, 1'b1, 1'b0, 8'h00);
      check_line("d_in_num",   "1d",   8'd13, 1'b0, 1'b1, 8'h00);
      check("d_in_num_dump", 32'(bus.dump_req), 32'h0);

      // Dump request handshake
      send_byte("d");
      check("dump_set", 32'(bus.dump_req), 32'h1);
      idle(3);
      check("dump_hold", 32'(bus.dump_req), 32'h1);
      send_byte("d");
      check("dump_repeat", 32'(bus.dump_req), 32'h1);
      bus.dump_ack = 1'b1;
      @(negedge clk);
      bus.dump_ack = 1'b0;
      check("dump_ack_clr", 32'(bus.dump_req), 32'h0);
      send_byte("d");
      bus.dump_ack = 1'b1;
      send_byte("d");
      bus.dump_ack = 1'b0;
      check("dump_ack_and_d", 32'(bus.dump_req), 32'h1);
      bus.dump_ack = 1'b1;
      @(negedge clk);
      bus.dump_ack = 1'b0;
      check("dump_ack_clr2", 32'(bus.dump_req), 32'h0);

      // Reset in the middle of a line drops it
      check_line("p7", "7", 8'd13, 1'b1, 1'b0, 8'h07);
      send_str("56");
      reset = 1'b0;
      #1;
      check("midrst_value", 32'(bus.value), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      nv = 0;
      ne = 0;
      send_byte(8'd13);
      idle(1);
      check("midrst_pulses", 32'(nv + ne),          32'h0);
      check("midrst_out",    32'(bus.value),        32'h0);
      check("midrst_dump",   32'(bus.dump_req),     32'h0);
      check_line("p9", "9", 8'd13, 1'b1, 1'b0, 8'h09);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_parser.md
Name: rx_parser

Overview:
- Receive-side companion to the UART transmit formatter: consumes bytes from the UART receiver and parses ASCII lines.
- A line holds either a signed decimal number (optional '-', then 1..MAX_DIGITS digits, ended by CR or LF) or the single-character dump command 'd'.
- A parsed number is presented as a signed DBIT-bit value with a one-cycle valid pulse.
- A 'd' command raises a level request toward the transmit formatter, which holds it until acknowledged.

Parameters:
- DBIT, 8: data bits per received byte and width of the parsed value.
- MAX_DIGITS, 3: maximum number of decimal digits accepted per line.
- ACC_W, 10: accumulator width. Must hold 10^MAX_DIGITS - 1 (999 needs 10 bits).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx_done_tick  in  1  one-cycle strobe from the UART receiver; rx_dout is valid in that cycle.
- rx_dout  in  DBIT  received byte.
- dump_ack  in  1  pulse from the transmit formatter; dump has been serviced.
- value  out  DBIT  signed parsed value; holds the last valid result.
- value_valid  out  1  one-cycle pulse when value updates.
- parse_err  out  1  one-cycle pulse on a rejected line.
- dump_req  out  1  level; set by a 'd' command, cleared by dump_ack.

Behaviour:
- Reset (reset=0, asynchronous): value=0, value_valid=0, parse_err=0, dump_req=0, acc=0, cnt=0, neg=0, state=IDLE.
- All outputs are registered. Effects of a byte accepted on rx_done_tick appear the next cycle (latency 1).
- Bytes are processed only in cycles with rx_done_tick=1. value_valid and parse_err are cleared every other cycle.
- Digit = byte in '0'..'9'; digit value = byte - 48. Terminator = 13 (CR) or 10 (LF).
- IDLE:
  - '-': neg=1, acc=0, cnt=0 -> DIGITS.
  - digit: neg=0, acc=d, cnt=1 -> DIGITS.
  - 'd': dump_req=1; stay IDLE.
  - terminator: ignored, so an empty line or the LF of a CRLF pair produces no pulse.
  - any other byte -> DISCARD.
- DIGITS:
  - digit with cnt<MAX_DIGITS: acc=acc*10+d, cnt=cnt+1.
  - digit with cnt==MAX_DIGITS -> DISCARD.
  - terminator with cnt==0 (lone '-'): parse_err pulse -> IDLE.
  - terminator with cnt>0: range check.
    - neg=0 and acc<=2^(DBIT-1)-1: value=acc.
    - neg=1 and acc<=2^(DBIT-1): value=-acc (two's complement, truncated to DBIT).
    - In range: value_valid pulse. Otherwise: parse_err pulse, value unchanged.
    - -> IDLE in either case.
  - any other byte (including 'd' and a second '-') -> DISCARD.
- DISCARD: ignores everything until a terminator, then parse_err pulse -> IDLE.
- Leading zeros count toward MAX_DIGITS ("0042" is rejected when MAX_DIGITS=3). "-0" yields value=0, valid.
- dump_req:
  - Cleared on dump_ack=1.
  - If a 'd' is accepted in the same cycle as dump_ack=1, dump_req stays 1 (the new request wins).
  - Repeated 'd' while dump_req=1 has no further effect.
- value_valid and parse_err are never asserted in the same cycle.
- State register 2 bits. The unused encoding returns to IDLE with no pulse.
- reset asserted mid-line: the partial line is dropped; no pulse is produced after release.

Test Plan:
- Bytes "1","2","7",CR -> one cycle after CR: value=8'h7F, value_valid=1 for exactly one cycle, parse_err=0.
- Bytes "-","1","2","8",LF -> value=8'h80 (-128), value_valid pulse. Then "1","2","8",CR -> parse_err pulse, value stays 8'h80.
- Bytes "4","2",CR,LF -> exactly one value_valid (value=8'h2A). The LF produces nothing. Then "-",CR -> parse_err pulse.
- Bytes "1","2","3","4",CR -> no value_valid; single parse_err pulse on CR. Same for "1","x","5",CR.
- Byte "d" -> dump_req=1 next cycle and held. dump_ack pulse -> dump_req=0 next cycle. "d" coinciding with dump_ack -> dump_req remains 1.
- Bytes "5","6", then reset=0 for 2 cycles, then release, then CR -> no pulses; all outputs 0. Then "9",CR -> value=9, value_valid pulse.
